glift_cmp_arbiter: RTL and testbench

GLIFT_CMP_ARBITER -- requirements
Module: glift_cmp_arbiter

---
 rtl/glift_cmp_arbiter_if.sv | 36 +++
 rtl/glift_cmp_arbiter.sv | 150 +++++++++++++++
 tb/tb_glift_cmp_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glift_cmp_arbiter_if.sv
// glift_cmp_arbiter_if
// Purpose: bundles the two requester channels, the response channel and
// the sticky taint flag of glift_cmp_arbiter into one interface.
// Signals:
//   req0_valid/req0_ready/req0_data  requester 0 handshake, data {b_t,a_t,b,a}
//   req1_valid/req1_ready/req1_data  requester 1 handshake, data {b_t,a_t,b,a}
//   rsp_valid/rsp_ready              response handshake
//   rsp_id                           owner of the response
//   rsp_res/rsp_res_t                {gt,eq,lt} result and its taint
//   taint_seen/taint_clr             sticky taint flag and its clear
// Modports: slave = the arbiter, master = whoever drives requests/consumes.
interface glift_cmp_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [2:0]  rsp_res;
    logic [2:0]  rsp_res_t;
    logic        taint_seen;
    logic        taint_clr;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready, taint_clr,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_res, rsp_res_t, taint_seen
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, rsp_ready, taint_clr,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_res, rsp_res_t, taint_seen
    );
endinterface

// File: rtl/glift_cmp_arbiter.sv
// glift_cmp_arbiter
// Purpose: round-robin arbiter in front of a 4-bit magnitude comparator that
// also tracks information flow (gate-level taint). One operation is in flight
// at a time: IDLE grants a requester, CMP evaluates, RESP holds the result
// until the consumer takes it.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    glift_cmp_arbiter_if.slave (requests, response, taint flag)
module glift_cmp_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    glift_cmp_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    state_t                 r_state;
    logic                   r_last;
    logic                   r_id;
    logic [4*WIDTH-1:0]     r_data;
    logic                   r_rspValid;
    logic                   r_rspId;
    logic [2:0]             r_rspRes;
    logic [2:0]             r_rspResT;
    logic                   r_taintSeen;

    logic                   w_pick0;
    logic                   w_pick1;
    logic                   w_idle;
    logic                   w_grant;
    logic [WIDTH-1:0][1:0]  w_e;
    logic [WIDTH-1:0][1:0]  w_g;
    logic [WIDTH-1:0][1:0]  w_l;
    logic [1:0]             w_gt;
    logic [1:0]             w_eq;
    logic [1:0]             w_lt;

    // Tainted bits are carried as {value, taint}. These helpers are the
    // precise GLIFT shadow rules: a tainted input only taints the output
    // when it can actually change the output given the other input.
    function automatic logic [1:0] tAnd(logic [1:0] x, logic [1:0] y);
        return {x[1] & y[1], (x[1] & y[0]) | (y[1] & x[0]) | (x[0] & y[0])};
    endfunction

    function automatic logic [1:0] tOr(logic [1:0] x, logic [1:0] y);
        return {x[1] | y[1], (~x[1] & y[0]) | (~y[1] & x[0]) | (x[0] & y[0])};
    endfunction

    function automatic logic [1:0] tNot(logic [1:0] x);
        return {~x[1], x[0]};
    endfunction

    function automatic logic [1:0] tXnor(logic [1:0] x, logic [1:0] y);
        return {~(x[1] ^ y[1]), x[0] | y[0]};
    endfunction

    // Round-robin choice: requester 1 wins when alone, or when both ask and
    // requester 0 was served last. Ready is only offered in IDLE and is held
    // low while reset is asserted so nothing can handshake during reset.
    assign w_pick1        = bus.req1_valid & (~bus.req0_valid | ~r_last);
    assign w_pick0        = bus.req0_valid & ~w_pick1;
    assign w_idle         = (r_state == IDLE) & rst_n;
    assign bus.req0_ready = w_idle & w_pick0;
    assign bus.req1_ready = w_idle & w_pick1;
    assign w_grant        = bus.req0_ready | bus.req1_ready;

    assign bus.rsp_valid  = r_rspValid;
    assign bus.rsp_id     = r_rspId;
    assign bus.rsp_res    = r_rspRes;
    assign bus.rsp_res_t  = r_rspResT;
    assign bus.taint_seen = r_taintSeen;

    // Per-bit equal/greater/less terms from the captured operands, then the
    // ripple-from-MSB comparator with products grouped left to right so the
    // taint of each intermediate gate matches the reference gate netlist.
    always_comb begin
        w_e = '0;
        w_g = '0;
        w_l = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_e[i] = tXnor({r_data[i], r_data[2*WIDTH+i]}, {r_data[WIDTH+i], r_data[3*WIDTH+i]});
            w_g[i] = tAnd({r_data[i], r_data[2*WIDTH+i]}, tNot({r_data[WIDTH+i], r_data[3*WIDTH+i]}));
            w_l[i] = tAnd(tNot({r_data[i], r_data[2*WIDTH+i]}), {r_data[WIDTH+i], r_data[3*WIDTH+i]});
        end
        w_gt = tOr(tOr(tOr(w_g[3], tAnd(w_e[3], w_g[2])),
                       tAnd(tAnd(w_e[3], w_e[2]), w_g[1])),
                   tAnd(tAnd(tAnd(w_e[3], w_e[2]), w_e[1]), w_g[0]));
        w_lt = tOr(tOr(tOr(w_l[3], tAnd(w_e[3], w_l[2])),
                       tAnd(tAnd(w_e[3], w_e[2]), w_l[1])),
                   tAnd(tAnd(tAnd(w_e[3], w_e[2]), w_e[1]), w_l[0]));
        w_eq = tAnd(w_e[0], tAnd(w_e[1], tAnd(w_e[3], w_e[2])));
    end

    // Main controller. Capture on grant, evaluate for exactly one cycle, then
    // hold the registered response until the consumer accepts it. Reset drops
    // any operation in flight so no stale response can appear afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_id       <= 1'b0;
            r_data     <= '0;
            r_rspValid <= 1'b0;
            r_rspId    <= 1'b0;
            r_rspRes   <= 3'b000;
            r_rspResT  <= 3'b000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_data  <= w_pick1 ? bus.req1_data : bus.req0_data;
                        r_id    <= w_pick1;
                        r_last  <= w_pick1;
                        r_state <= CMP;
                    end
                end
                CMP: begin
                    r_rspValid <= 1'b1;
                    r_rspId    <= r_id;
                    r_rspRes   <= {w_gt[1], w_eq[1], w_lt[1]};
                    r_rspResT  <= {w_gt[0], w_eq[0], w_lt[0]};
                    r_state    <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky record that tainted data left the block. Setting wins over a
    // simultaneous clear so a tainted result is never silently lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taintSeen <= 1'b0;
        end else if (r_rspValid & bus.rsp_ready & (|r_rspResT)) begin
            r_taintSeen <= 1'b1;
        end else if (bus.taint_clr) begin
            r_taintSeen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_glift_cmp_arbiter.sv
// tb_glift_cmp_arbiter
// Purpose: self-checking bench for glift_cmp_arbiter. A table of operand
// vectors with expected results is pushed through one requester at a time,
// followed by hand-written round-robin, backpressure, taint-clear and
// reset-abort sequences. Expected responses go into a scoreboard queue when a
// grant happens and are compared when the response handshake occurs.
module tb_glift_cmp_arbiter;

    typedef struct packed {
        logic       id;
        logic [2:0] res;
        logic [2:0] rest;
    } expT;

    typedef struct {
        logic        id;
        logic [15:0] data;
        logic [2:0]  res;
        logic [2:0]  rest;
    } vecT;

    typedef struct packed {
        logic v;
        logic t;
    } tbit;

    logic clk;
    logic rst_n;
    glift_cmp_arbiter_if bus();

    int   total;
    int   bad;
    logic seenModel;
    expT  sb[$];
    vecT  vecs[10];

    glift_cmp_arbiter #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference taint algebra, written independently as {v,t} records.
    function automatic tbit mAnd(tbit x, tbit y);
        tbit r;
        r.v = x.v & y.v;
        r.t = (x.v & y.t) | (y.v & x.t) | (x.t & y.t);
        return r;
    endfunction

    function automatic tbit mOr(tbit x, tbit y);
        tbit r;
        r.v = x.v | y.v;
        r.t = (~x.v & y.t) | (~y.v & x.t) | (x.t & y.t);
        return r;
    endfunction

    function automatic tbit mNot(tbit x);
        tbit r;
        r.v = ~x.v;
        r.t = x.t;
        return r;
    endfunction

    function automatic tbit mXnor(tbit x, tbit y);
        tbit r;
        r.v = (x.v == y.v);
        r.t = x.t | y.t;
        return r;
    endfunction

    function automatic expT model(logic id, logic [15:0] d);
        tbit a[4];
        tbit b[4];
        tbit e[4];
        tbit g[4];
        tbit l[4];
        tbit gt;
        tbit eq;
        tbit lt;
        expT r;
        for (int i = 0; i < 4; i++) begin
            a[i].v = d[i];
            a[i].t = d[8+i];
            b[i].v = d[4+i];
            b[i].t = d[12+i];
            e[i] = mXnor(a[i], b[i]);
            g[i] = mAnd(a[i], mNot(b[i]));
            l[i] = mAnd(mNot(a[i]), b[i]);
        end
        gt = mOr(mOr(mOr(g[3], mAnd(e[3], g[2])), mAnd(mAnd(e[3], e[2]), g[1])),
                 mAnd(mAnd(mAnd(e[3], e[2]), e[1]), g[0]));
        lt = mOr(mOr(mOr(l[3], mAnd(e[3], l[2])), mAnd(mAnd(e[3], e[2]), l[1])),
                 mAnd(mAnd(mAnd(e[3], e[2]), e[1]), l[0]));
        eq = mAnd(e[0], mAnd(e[1], mAnd(e[3], e[2])));
        r.id   = id;
        r.res  = {gt.v, eq.v, lt.v};
        r.rest = {gt.t, eq.t, lt.t};
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Pulse reset across a couple of cycles, aligned to the falling edge.
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        seenModel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Raise one requester's valid, wait (bounded) for its ready, let the
    // handshake edge pass, and drop valid. Returns at the falling edge of the
    // CMP cycle. The expected result is queued only when a grant happens.
    task automatic applyStimulus(input logic id, input logic [15:0] data, input logic push);
        int n;
        logic rdy;
        if (id) begin
            bus.req1_data  = data;
            bus.req1_valid = 1'b1;
        end else begin
            bus.req0_data  = data;
            bus.req0_valid = 1'b1;
        end
        n = 0;
        #1;
        rdy = id ? bus.req1_ready : bus.req0_ready;
        while (!rdy && n < 20) begin
            @(negedge clk);
            #1;
            rdy = id ? bus.req1_ready : bus.req0_ready;
            n++;
        end
        if (!rdy) begin
            checkOutput("grantTimeout", 16'(rdy), 16'd1);
        end else begin
            if (push) sb.push_back(model(id, data));
            @(posedge clk);
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Wait (bounded) for a response, compare against the scoreboard head,
    // accept it with an optional simultaneous taint_clr, and check the
    // sticky taint flag one cycle later.
    task automatic collectResponse(input logic clr);
        int  n;
        expT e;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) begin
            checkOutput("rspTimeout", 16'(bus.rsp_valid), 16'd1);
            return;
        end
        if (sb.size() == 0) begin
            checkOutput("rspUnexpected", 16'(bus.rsp_valid), 16'd0);
            return;
        end
        e = sb.pop_front();
        checkOutput("rspId", 16'(bus.rsp_id), 16'(e.id));
        checkOutput("rspRes", 16'(bus.rsp_res), 16'(e.res));
        checkOutput("rspResT", 16'(bus.rsp_res_t), 16'(e.rest));
        bus.rsp_ready = 1'b1;
        bus.taint_clr = clr;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.taint_clr = 1'b0;
        seenModel = (e.rest != 3'b000) | (seenModel & ~clr);
        checkOutput("rspDrop", 16'(bus.rsp_valid), 16'd0);
        checkOutput("taintSeen", 16'(bus.taint_seen), 16'(seenModel));
    endtask

    initial begin
        logic [15:0] d0;
        logic [15:0] d1;
        expT         e;
        total = 0;
        bad   = 0;
        seenModel = 1'b0;
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 16'h0000;
        bus.req1_valid = 1'b0;
        bus.req1_data  = 16'h0000;
        bus.rsp_ready  = 1'b0;
        bus.taint_clr  = 1'b0;

        // Reset state, including ready held low despite a valid request.
        #12;
        checkOutput("rstReady0", 16'(bus.req0_ready), 16'd0);
        checkOutput("rstReady1", 16'(bus.req1_ready), 16'd0);
        checkOutput("rstRspValid", 16'(bus.rsp_valid), 16'd0);
        checkOutput("rstRspId", 16'(bus.rsp_id), 16'd0);
        checkOutput("rstRspRes", 16'(bus.rsp_res), 16'd0);
        checkOutput("rstRspResT", 16'(bus.rsp_res_t), 16'd0);
        checkOutput("rstTaintSeen", 16'(bus.taint_seen), 16'd0);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: hand-derived entries first, then model-derived ones.
        vecs[0] = '{1'b0, 16'h00FF, 3'b010, 3'b000};
        vecs[1] = '{1'b1, 16'h08F7, 3'b001, 3'b011};
        vecs[2] = '{1'b0, 16'hFF7F, 3'b100, 3'b111};
        vecs[3] = '{1'b0, 16'h0053, 3'b001, 3'b000};
        vecs[4] = '{1'b1, 16'h0199, 3'b010, 3'b011};
        for (int i = 5; i < 10; i++) begin
            vecs[i].id   = 1'($urandom_range(0, 1));
            vecs[i].data = 16'($urandom);
            e = model(vecs[i].id, vecs[i].data);
            vecs[i].res  = e.res;
            vecs[i].rest = e.rest;
        end

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].id, vecs[i].data, 1'b0);
            sb.push_back('{vecs[i].id, vecs[i].res, vecs[i].rest});
            checkOutput("cmpNoValid", 16'(bus.rsp_valid), 16'd0);
            checkOutput("cmpReady0", 16'(bus.req0_ready), 16'd0);
            @(negedge clk);
            checkOutput("latency", 16'(bus.rsp_valid), 16'd1);
            collectResponse(1'b0);
        end

        // Clearing the sticky flag, then a tainted handshake with clear asserted.
        @(negedge clk);
        bus.taint_clr = 1'b1;
        @(negedge clk);
        bus.taint_clr = 1'b0;
        seenModel = 1'b0;
        checkOutput("taintClr", 16'(bus.taint_seen), 16'd0);
        applyStimulus(1'b1, 16'h08F7, 1'b1);
        collectResponse(1'b1);
        checkOutput("setWinsClr", 16'(bus.taint_seen), 16'd1);

        // Round robin with both requesters continuously valid after reset.
        doReset();
        d0 = 16'h0035;
        d1 = 16'h10AA;
        bus.req0_data  = d0;
        bus.req1_data  = d1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("rrReady0", 16'(bus.req0_ready), 16'(k % 2 == 0));
            checkOutput("rrReady1", 16'(bus.req1_ready), 16'(k % 2 == 1));
            sb.push_back(model(1'(k % 2), (k % 2 == 0) ? d0 : d1));
            @(posedge clk);
            @(negedge clk);
            collectResponse(1'b0);
        end

        // Backpressure: response must hold and nothing new may be granted.
        #1;
        checkOutput("holdGrant0", 16'(bus.req0_ready), 16'd1);
        e = model(1'b0, d0);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("holdValid0", 16'(bus.rsp_valid), 16'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("holdValid", 16'(bus.rsp_valid), 16'd1);
            checkOutput("holdId", 16'(bus.rsp_id), 16'(e.id));
            checkOutput("holdRes", 16'(bus.rsp_res), 16'(e.res));
            checkOutput("holdResT", 16'(bus.rsp_res_t), 16'(e.rest));
            checkOutput("holdReady0", 16'(bus.req0_ready), 16'd0);
            checkOutput("holdReady1", 16'(bus.req1_ready), 16'd0);
        end
        collectResponse(1'b0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Reset during CMP: nothing may emerge after release.
        @(negedge clk);
        applyStimulus(1'b0, 16'h0012, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("rstCmpValid", 16'(bus.rsp_valid), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("rstCmpNoRsp", 16'(bus.rsp_valid), 16'd0);
        end

        // Reset during RESP: outputs clear asynchronously and stay quiet.
        applyStimulus(1'b1, 16'h00F0, 1'b0);
        @(negedge clk);
        checkOutput("preRstValid", 16'(bus.rsp_valid), 16'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstRespValid", 16'(bus.rsp_valid), 16'd0);
        checkOutput("rstRespId", 16'(bus.rsp_id), 16'd0);
        checkOutput("rstRespRes", 16'(bus.rsp_res), 16'd0);
        checkOutput("rstRespResT", 16'(bus.rsp_res_t), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("rstRespNoRsp", 16'(bus.rsp_valid), 16'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
